pong_score: RTL and testbench
=============================

PONG_SCORE -- requirements
Module: pong_score

Interface
REQ-001 Parameter BALLS_INIT, default 3, balls granted per game; legal range 1..3.
REQ-002 Parameter TIMER_TICKS, default 120, inter-round pause length in tick60 pulses (2 s at 60 Hz); legal range 1..127.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick60  input  1  one-cycle pulse per video frame, from the VGA sync stage.
REQ-006 hit  input  1  one-cycle pulse, ball struck by a paddle, from the graphics stage.
REQ-007 miss  input  1  one-cycle pulse, ball left the field, from the graphics stage.
REQ-008 clr  input  1  one-cycle pulse, start new game, from the top-level game FSM.
REQ-009 timer_start  input  1  one-cycle pulse, arm the pause timer, from the top-level game FSM.
REQ-010 dig0  output  4  score units digit, BCD.
REQ-011 dig1  output  4  score tens digit, BCD.
REQ-012 balls  output  2  balls remaining.
REQ-013 game_over  output  1  level; no balls remain.
REQ-014 timer_up  output  1  level; pause timer is expired or idle.

Function
REQ-015 All outputs are registered; every input takes effect one cycle after sampling.
REQ-016 Score: on hit, when game_over=0 and score<99, add 1 in BCD.
- dig0=9 wraps to 0 and dig1 increments.
- Score 99 saturates; dig0 and dig1 hold.
REQ-017 Hit while game_over=1 is ignored.
REQ-018 Balls: on miss, when balls>0, decrement balls by 1.
- Transition from 1 to 0 sets game_over=1 in the same cycle balls reaches 0.
REQ-019 Miss while balls=0 is ignored; balls never underflows.
REQ-020 game_over equals (balls==0) at all times outside reset.
REQ-021 Simultaneous hit and miss with balls>=2: both apply in the same cycle.
REQ-022 Simultaneous hit and miss with balls=1: the hit is scored, then game_over asserts.
REQ-023 clr loads dig0=0, dig1=0, balls=BALLS_INIT and clears game_over.
- clr has priority over hit and miss in the same cycle.
- clr does not affect the timer.
REQ-024 Timer: a 7-bit down-counter. timer_start loads TIMER_TICKS.
- Each tick60 decrements the counter while it is nonzero.
- The counter holds at 0.
REQ-025 timer_up=1 exactly when the counter is 0.
REQ-026 timer_start coincident with tick60: the load wins, with no decrement that cycle.
REQ-027 timer_start while the counter is running reloads TIMER_TICKS (restart).
REQ-028 Without tick60, the counter holds its value indefinitely.
REQ-029 hit, miss and clr have no effect on the timer.
REQ-030 No internal prescaler; timing derives solely from tick60.

Reset
REQ-031 Reset drives dig0=0, dig1=0, balls=BALLS_INIT, game_over=0, timer counter=0 and timer_up=1.
REQ-032 Reset has priority over every other input; a hit, miss, clr or timer_start coincident with reset is discarded.
REQ-033 Reset mid-pause clears the counter immediately; timer_up=1 on the cycle after reset.

Verification
REQ-034 Reset, then 10 hit pulses -> dig1=1, dig0=0; after 99 total hits plus 3 more -> dig1=9, dig0=9.
REQ-035 BALLS_INIT=3, 3 miss pulses -> balls 2,1,0 with game_over=1 after the third; a 4th miss -> balls stays 0; a subsequent hit -> score unchanged.
REQ-036 Score 05, balls 0, clr coincident with hit -> next cycle dig1=0, dig0=0, balls=3, game_over=0.
REQ-037 TIMER_TICKS=120, timer_start then 119 tick60 -> timer_up=0; 120th tick60 -> timer_up=1 the following cycle.
REQ-038 timer_start coincident with tick60, then timer_start again after 50 ticks -> timer_up stays 0 until 120 further ticks.
REQ-039 balls=1, hit and miss in the same cycle, score 42 -> score 43, balls 0, game_over=1.

Source files
------------

// File: rtl/pong_score_if.sv
// Pong scoring event and status bundle.
// The game side drives event pulses and reads back score and timer state.
interface pong_score_if;
   logic       tick60;
   logic       hit;
   logic       miss;
   logic       clr;
   logic       timer_start;
   logic [3:0] dig0;
   logic [3:0] dig1;
   logic [1:0] balls;
   logic       game_over;
   logic       timer_up;

   modport master (
      output tick60, hit, miss, clr, timer_start,
      input  dig0, dig1, balls, game_over, timer_up
   );

   modport slave (
      input  tick60, hit, miss, clr, timer_start,
      output dig0, dig1, balls, game_over, timer_up
   );
endinterface

// File: rtl/pong_score.sv
// Pong score keeper: BCD score, balls remaining and inter-round pause timer.
// All outputs are registered and follow their inputs by one cycle.
module pong_score #(
   parameter int BALLS_INIT  = 3,
   parameter int TIMER_TICKS = 120
) (
   input  logic        clk,
   input  logic        reset,
   pong_score_if.slave bus
);

   localparam logic [1:0] BALLS_RST = 2'(BALLS_INIT);
   localparam logic [6:0] TICKS     = 7'(TIMER_TICKS);

   logic [3:0] dig0_q;
   logic [3:0] dig1_q;
   logic [1:0] balls_q;
   logic       over_q;
   logic [6:0] tmr_q;
   logic [6:0] tmr_nxt;
   logic       up_q;
   logic       at_max;
   logic       do_hit;

   assign at_max = (dig1_q == 4'd9) && (dig0_q == 4'd9);
   assign do_hit = bus.hit && !over_q && !at_max;

   always_ff @(posedge clk) begin
      if (reset) begin
         dig0_q  <= 4'd0;
         dig1_q  <= 4'd0;
         balls_q <= BALLS_RST;
         over_q  <= 1'b0;
      end else if (bus.clr) begin
         dig0_q  <= 4'd0;
         dig1_q  <= 4'd0;
         balls_q <= BALLS_RST;
         over_q  <= 1'b0;
      end else begin
         if (do_hit) begin
            if (dig0_q == 4'd9) begin
               dig0_q <= 4'd0;
               dig1_q <= dig1_q + 4'd1;
            end else begin
               dig0_q <= dig0_q + 4'd1;
            end
         end
         if (bus.miss && balls_q != 2'd0) begin
            balls_q <= balls_q - 2'd1;
            if (balls_q == 2'd1)
               over_q <= 1'b1;
         end
      end
   end

   // A load always beats a coincident tick.
   always_comb begin
      tmr_nxt = tmr_q;
      if (bus.timer_start)
         tmr_nxt = TICKS;
      else if (bus.tick60 && tmr_q != 7'd0)
         tmr_nxt = tmr_q - 7'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q <= 7'd0;
         up_q  <= 1'b1;
      end else begin
         tmr_q <= tmr_nxt;
         up_q  <= (tmr_nxt == 7'd0);
      end
   end

   assign bus.dig0      = dig0_q;
   assign bus.dig1      = dig1_q;
   assign bus.balls     = balls_q;
   assign bus.game_over = over_q;
   assign bus.timer_up  = up_q;

endmodule

// File: tb/tb_pong_score.sv
// Bench for pong_score: per-cycle comparison against a score/balls/timer model
// plus directed vectors with hand-computed expectations.
module tb_pong_score;

   logic clk;
   logic reset;
   pong_score_if bus ();

   pong_score #(.BALLS_INIT(3), .TIMER_TICKS(120)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   int m_score = 0;
   int m_balls = 3;
   int m_tmr   = 0;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: score as an integer, balls as a count, timer as a tick count.
   always @(posedge clk) begin
      if (reset) begin
         m_score <= 0;
         m_balls <= 3;
         m_tmr   <= 0;
      end else begin
         if (bus.clr) begin
            m_score <= 0;
            m_balls <= 3;
         end else begin
            if (bus.hit && m_balls > 0 && m_score < 99)
               m_score <= m_score + 1;
            if (bus.miss && m_balls > 0)
               m_balls <= m_balls - 1;
         end
         if (bus.timer_start)
            m_tmr <= 120;
         else if (bus.tick60 && m_tmr > 0)
            m_tmr <= m_tmr - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_dig0", int'(bus.dig0), m_score % 10);
         check("m_dig1", int'(bus.dig1), m_score / 10);
         check("m_balls", int'(bus.balls), m_balls);
         check("m_over", int'(bus.game_over), int'(m_balls == 0));
         check("m_tup", int'(bus.timer_up), int'(m_tmr == 0));
      end
   end

   task automatic step(input logic h, input logic m, input logic c,
                       input logic ts, input logic tk);
      bus.hit         = h;
      bus.miss        = m;
      bus.clr         = c;
      bus.timer_start = ts;
      bus.tick60      = tk;
      @(posedge clk);
      #1;
      bus.hit         = 0;
      bus.miss        = 0;
      bus.clr         = 0;
      bus.timer_start = 0;
      bus.tick60      = 0;
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0);
      end
   endtask

   task automatic score_is(input string name, input int d1, input int d0);
      check({name, "_d1"}, int'(bus.dig1), d1);
      check({name, "_d0"}, int'(bus.dig0), d0);
   endtask

   initial begin
      reset = 1;
      bus.hit = 0;
      bus.miss = 0;
      bus.clr = 0;
      bus.timer_start = 0;
      bus.tick60 = 0;
      step(0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1);
      reset = 0;
      chk_en = 1;

      score_is("rst", 0, 0);
      check("rst_balls", int'(bus.balls), 3);
      check("rst_over", int'(bus.game_over), 0);
      check("rst_tup", int'(bus.timer_up), 1);

      hits(10);
      score_is("hit10", 1, 0);
      hits(89);
      score_is("hit99", 9, 9);
      hits(3);
      score_is("sat", 9, 9);

      reset = 1;
      step(1, 1, 0, 0, 0);
      reset = 0;
      score_is("rst_hit", 0, 0);
      check("rst_miss", int'(bus.balls), 3);

      hits(5);
      step(0, 1, 0, 0, 0);
      check("miss1", int'(bus.balls), 2);
      step(0, 1, 0, 0, 0);
      check("miss2", int'(bus.balls), 1);
      check("miss2_over", int'(bus.game_over), 0);
      step(0, 1, 0, 0, 0);
      check("miss3", int'(bus.balls), 0);
      check("miss3_over", int'(bus.game_over), 1);
      step(0, 1, 0, 0, 0);
      check("miss4", int'(bus.balls), 0);
      step(1, 0, 0, 0, 0);
      score_is("hit_over", 0, 5);

      step(1, 0, 1, 0, 0);
      score_is("clr_hit", 0, 0);
      check("clr_balls", int'(bus.balls), 3);
      check("clr_over", int'(bus.game_over), 0);

      hits(42);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("b1", int'(bus.balls), 1);
      step(1, 1, 0, 0, 0);
      score_is("hm1", 4, 3);
      check("hm1_balls", int'(bus.balls), 0);
      check("hm1_over", int'(bus.game_over), 1);

      step(0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      score_is("hm3", 0, 1);
      check("hm3_balls", int'(bus.balls), 2);

      step(0, 0, 0, 1, 0);
      check("ts_load", int'(bus.timer_up), 0);
      ticks(60);
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
      check("hold", int'(bus.timer_up), 0);
      ticks(59);
      check("t119", int'(bus.timer_up), 0);
      ticks(1);
      check("t120", int'(bus.timer_up), 1);
      ticks(3);
      check("t_idle", int'(bus.timer_up), 1);

      step(0, 0, 0, 1, 1);
      ticks(50);
      step(0, 0, 0, 1, 0);
      ticks(119);
      check("rs119", int'(bus.timer_up), 0);
      ticks(1);
      check("rs120", int'(bus.timer_up), 1);

      step(0, 0, 0, 1, 0);
      ticks(10);
      reset = 1;
      step(0, 0, 0, 1, 1);
      reset = 0;
      check("rst_mid", int'(bus.timer_up), 1);
      step(0, 0, 0, 0, 0);
      check("rst_mid2", int'(bus.timer_up), 1);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
